// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one byte-wide transmitter interface (e.g. the board UART) among
// NUM_REQUESTERS independent byte streams. Ownership is granted per frame
// with round-robin fairness, so bytes of different frames never interleave
// on the serial line. Optionally a grant is cut short after MAX_BURST bytes
// so one long frame cannot starve the others.
//
// Handshake semantics (all byte interfaces): a byte moves on a rising clock
// edge where valid and ready are both high. A producer keeps valid and its
// data stable until the byte is accepted; ready may change freely.
//
// Ports:
//   clock        system clock
//   reset        asynchronous, active-low reset
//   req_data     one byte per requester, requester i on [8i+7:8i]
//   req_valid    byte valid per requester
//   req_last     byte is the final byte of its frame
//   req_ready    byte accepted when req_valid[i] && req_ready[i]
//   tx_data      byte to the transmitter
//   tx_valid     byte valid to the transmitter
//   tx_ready     transmitter can accept a byte
//   grant_valid  a requester currently owns the transmitter
//   grant_index  owning requester (meaningful while grant_valid is high)
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter  int NUM_REQUESTERS = 4,
    parameter  int MAX_BURST      = 0,
    localparam int INDEX_BITS     = $clog2(NUM_REQUESTERS)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [8*NUM_REQUESTERS-1:0] req_data,
    input  logic [NUM_REQUESTERS-1:0]   req_valid,
    input  logic [NUM_REQUESTERS-1:0]   req_last,
    output logic [NUM_REQUESTERS-1:0]   req_ready,
    output logic [7:0]                  tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic                        grant_valid,
    output logic [INDEX_BITS-1:0]       grant_index
);

    // Burst counter is at least one bit wide even when bursts are unlimited.
    localparam int BURST_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);

    // With unlimited bursts the counter only saturates at its all-ones value;
    // it never causes a release in that case.
    localparam logic [BURST_W-1:0] BURST_CAP =
        (MAX_BURST == 0) ? {BURST_W{1'b1}} : BURST_W'(MAX_BURST);
    localparam logic [BURST_W-1:0] BURST_LAST =
        (MAX_BURST == 0) ? '0 : BURST_W'(MAX_BURST - 1);

    localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(NUM_REQUESTERS - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [INDEX_BITS-1:0] grant_q;
    logic [INDEX_BITS-1:0] grant_d;
    logic [INDEX_BITS-1:0] last_q;
    logic [INDEX_BITS-1:0] last_d;
    logic [BURST_W-1:0]    burst_q;
    logic [BURST_W-1:0]    burst_d;

    logic [INDEX_BITS-1:0] winner;
    logic [INDEX_BITS-1:0] cand;
    logic                  found;
    logic [7:0]            sel_data;
    logic                  handshake;
    logic                  rel;

    // Round-robin search: start one past the previous owner and walk upward,
    // wrapping explicitly at NUM_REQUESTERS-1 so non-power-of-two counts work.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = last_q;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            cand = (cand == LAST_IDX) ? '0 : cand + INDEX_BITS'(1);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign sel_data = req_data[{grant_q, 3'b000} +: 8];

    // Next-state and outputs. tx_valid depends only on the registered grant
    // and req_valid, never on tx_ready.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        burst_d   = burst_q;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        req_ready = '0;
        handshake = 1'b0;
        rel       = 1'b0;

        case (state_q)
            IDLE: begin
                // Arbitration cycle: no byte moves, the winner is registered.
                if (found) begin
                    state_d = GRANTED;
                    grant_d = winner;
                    burst_d = '0;
                end
            end

            GRANTED: begin
                tx_data            = sel_data;
                tx_valid           = req_valid[grant_q];
                req_ready[grant_q] = tx_ready;
                handshake          = req_valid[grant_q] && tx_ready;

                if (handshake) begin
                    burst_d = (burst_q == BURST_CAP) ? burst_q : burst_q + BURST_W'(1);
                    rel     = req_last[grant_q] ||
                              ((MAX_BURST != 0) && (burst_q == BURST_LAST));
                    if (rel) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_IDX;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

    assign grant_valid = (state_q == GRANTED);
    assign grant_index = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Two arbiters side by side: dut0 with unlimited bursts, dut1 with
// MAX_BURST=2. Each has its own set of randomized frame producers and its own
// reference model (integer owner / previous owner / bytes-this-grant), which
// predicts every output each cycle. Handshaked bytes go through an expected
// queue so the transmitted byte order is also checked.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N = 4;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    // ---------------- DUT signals (index = dut number) ----------------
    logic [8*N-1:0] req_data    [2];
    logic [N-1:0]   req_valid   [2];
    logic [N-1:0]   req_last    [2];
    logic [N-1:0]   req_ready   [2];
    logic [7:0]     tx_data     [2];
    logic           tx_valid    [2];
    logic           tx_ready    [2];
    logic           grant_valid [2];
    logic [1:0]     grant_index [2];

    uart_tx_arbiter #(.NUM_REQUESTERS(N), .MAX_BURST(0)) dut0 (
        .clock       (clock),
        .reset       (reset),
        .req_data    (req_data[0]),
        .req_valid   (req_valid[0]),
        .req_last    (req_last[0]),
        .req_ready   (req_ready[0]),
        .tx_data     (tx_data[0]),
        .tx_valid    (tx_valid[0]),
        .tx_ready    (tx_ready[0]),
        .grant_valid (grant_valid[0]),
        .grant_index (grant_index[0])
    );

    uart_tx_arbiter #(.NUM_REQUESTERS(N), .MAX_BURST(2)) dut1 (
        .clock       (clock),
        .reset       (reset),
        .req_data    (req_data[1]),
        .req_valid   (req_valid[1]),
        .req_last    (req_last[1]),
        .req_ready   (req_ready[1]),
        .tx_data     (tx_data[1]),
        .tx_valid    (tx_valid[1]),
        .tx_ready    (tx_ready[1]),
        .grant_valid (grant_valid[1]),
        .grant_index (grant_index[1])
    );

    // ---------------- counters ----------------
    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    int own    [2];   // owning requester, -1 when nobody owns the line
    int lastg  [2];   // previous owner, start point of the round-robin search
    int nbytes [2];   // bytes moved in the current grant

    // ---------------- producers ----------------
    int         p_rem   [2][N];  // bytes left in current frame (0 = no frame)
    int         p_sent  [2][N];  // bytes of current frame already accepted
    int         p_pause [2][N];  // cycles left with valid dropped mid-frame
    logic [7:0] p_byte  [2][N];
    logic [7:0] base    [N];

    logic [N-1:0] mask;
    int  start_pct, ready_pct, pause_pct, pause_max, len_min, len_max;
    bit  seq_data;

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];
    logic       obs_hs   [2];
    logic [7:0] obs_byte [2];

    // grant order log
    bit   rec;
    logic prev_gv [2];
    int   glog    [2][8];
    int   gcount  [2];

    function automatic int mb(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic q_push(input int d, input logic [7:0] b);
        if (d == 0) exp_q0.push_back(b);
        else        exp_q1.push_back(b);
    endtask

    function automatic int q_size(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [7:0] q_pop(input int d);
        if (d == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    // Producer i of dut d had a byte accepted.
    task automatic accept(input int d, input int i);
        p_rem[d][i]--;
        p_sent[d][i]++;
        if (p_rem[d][i] == 0) p_sent[d][i] = 0;
        else if (seq_data)    p_byte[d][i] = p_byte[d][i] + 8'd1;
        else                  p_byte[d][i] = 8'($urandom_range(0, 255));
    endtask

    // Advance the model across one rising edge, using the inputs that were
    // applied before that edge.
    task automatic step(input int d);
        bit         hs;
        bit         lst;
        logic [7:0] b;
        int         o;
        string      p;
        p  = $sformatf("d%0d", d);
        hs = 0;
        b  = '0;
        if (!reset) begin
            own[d]    = -1;
            lastg[d]  = N - 1;
            nbytes[d] = 0;
        end else if (own[d] < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c = (lastg[d] + k) % N;
                if (own[d] < 0 && req_valid[d][c]) begin
                    own[d]    = c;
                    nbytes[d] = 0;
                end
            end
        end else begin
            o = own[d];
            if (req_valid[d][o] && tx_ready[d]) begin
                hs  = 1;
                b   = req_data[d][o*8 +: 8];
                lst = req_last[d][o];
                nbytes[d]++;
                accept(d, o);
                if (lst || (mb(d) != 0 && nbytes[d] == mb(d))) begin
                    lastg[d] = o;
                    own[d]   = -1;
                end
            end
        end
        if (hs) q_push(d, b);
        if (obs_hs[d]) begin
            check_eq({p, "_hs_expected"}, q_size(d) > 0, 1);
            if (q_size(d) > 0) check_eq({p, "_tx_byte"}, obs_byte[d], q_pop(d));
        end
    endtask

    // Apply fresh producer / transmitter inputs.
    task automatic drive(input int d);
        tx_ready[d] = ($urandom_range(1, 100) <= ready_pct);
        for (int i = 0; i < N; i++) begin
            if (p_pause[d][i] > 0) p_pause[d][i]--;
            if (p_rem[d][i] == 0 && mask[i] && $urandom_range(1, 100) <= start_pct) begin
                p_rem[d][i]  = $urandom_range(len_min, len_max);
                p_sent[d][i] = 0;
                p_byte[d][i] = seq_data ? base[i] : 8'($urandom_range(0, 255));
            end
            if (p_rem[d][i] > 0 && p_sent[d][i] > 0 && own[d] == i && p_pause[d][i] == 0 &&
                $urandom_range(1, 100) <= pause_pct)
                p_pause[d][i] = $urandom_range(1, pause_max);
            req_valid[d][i]        = (p_rem[d][i] > 0) && (p_pause[d][i] == 0);
            req_last[d][i]         = (p_rem[d][i] == 1);
            req_data[d][i*8 +: 8]  = p_byte[d][i];
        end
    endtask

    task automatic check_out(input int d);
        logic [N-1:0] er;
        logic         ev;
        logic [7:0]   ed;
        string        p;
        p  = $sformatf("d%0d", d);
        er = '0;
        ev = 1'b0;
        ed = '0;
        if (own[d] >= 0) begin
            ev = req_valid[d][own[d]];
            ed = req_data[d][own[d]*8 +: 8];
            if (tx_ready[d]) er[own[d]] = 1'b1;
            check_eq({p, "_grant_index"}, grant_index[d], own[d]);
        end
        check_eq({p, "_grant_valid"}, grant_valid[d], own[d] >= 0);
        check_eq({p, "_tx_valid"}, tx_valid[d], ev);
        check_eq({p, "_tx_data"}, tx_data[d], ed);
        check_eq({p, "_req_ready"}, req_ready[d], er);
        obs_hs[d]   = tx_valid[d] && tx_ready[d];
        obs_byte[d] = tx_data[d];
        if (rec && grant_valid[d] && !prev_gv[d]) begin
            if (gcount[d] < 8) glog[d][gcount[d]] = grant_index[d];
            gcount[d]++;
        end
        prev_gv[d] = grant_valid[d];
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++) step(d);
        for (int d = 0; d < 2; d++) drive(d);
        #1;
        for (int d = 0; d < 2; d++) check_out(d);
    endtask

    // Asserts reset between clock edges, checks the asynchronous effect,
    // holds it for three cycles and releases it on a falling edge.
    task automatic do_reset(input bit clear_prod);
        #1;
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d_rst_grant_valid", d), grant_valid[d], 0);
            check_eq($sformatf("d%0d_rst_tx_valid", d), tx_valid[d], 0);
            check_eq($sformatf("d%0d_rst_req_ready", d), req_ready[d], 0);
            check_eq($sformatf("d%0d_rst_tx_data", d), tx_data[d], 0);
            obs_hs[d]  = 1'b0;
            own[d]     = -1;
            lastg[d]   = N - 1;
            nbytes[d]  = 0;
            prev_gv[d] = 1'b0;
            for (int i = 0; i < N; i++) begin
                p_pause[d][i] = 0;
                if (clear_prod) begin
                    p_rem[d][i]  = 0;
                    p_sent[d][i] = 0;
                end
            end
        end
        repeat (3) cycle();
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_data[d]  = '0;
            req_valid[d] = '0;
            req_last[d]  = '0;
            tx_ready[d]  = 1'b0;
            own[d]       = -1;
            lastg[d]     = N - 1;
            nbytes[d]    = 0;
            obs_hs[d]    = 1'b0;
            obs_byte[d]  = '0;
            prev_gv[d]   = 1'b0;
            gcount[d]    = 0;
            for (int i = 0; i < N; i++) begin
                p_rem[d][i]   = 0;
                p_sent[d][i]  = 0;
                p_pause[d][i] = 0;
                p_byte[d][i]  = '0;
            end
            for (int k = 0; k < 8; k++) glog[d][k] = -1;
        end
        for (int i = 0; i < N; i++) base[i] = '0;
        mask = '0; start_pct = 0; ready_pct = 100; pause_pct = 0; pause_max = 1;
        len_min = 1; len_max = 1; seq_data = 0; rec = 0;

        // reset state
        do_reset(1);
        for (int d = 0; d < 2; d++)
            check_eq($sformatf("d%0d_rst_grant_index", d), grant_index[d], 0);

        // single requester, 3-byte frame 0x41 0x42 0x43
        mask = 4'b0001; start_pct = 100; len_min = 3; len_max = 3;
        seq_data = 1; base[0] = 8'h41; ready_pct = 100;
        repeat (12) cycle();

        // everybody requesting 1-byte frames: round-robin order from reset
        mask = 4'b1111; len_min = 1; len_max = 1;
        for (int i = 0; i < N; i++) base[i] = 8'hA0 + 8'(i);
        do_reset(1);
        rec = 1;
        repeat (20) cycle();
        rec = 0;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d_grant_count", d), gcount[d] >= 5, 1);
            check_eq($sformatf("d%0d_order0", d), glog[d][0], 0);
            check_eq($sformatf("d%0d_order1", d), glog[d][1], 1);
            check_eq($sformatf("d%0d_order2", d), glog[d][2], 2);
            check_eq($sformatf("d%0d_order3", d), glog[d][3], 3);
            check_eq($sformatf("d%0d_order4", d), glog[d][4], 0);
        end

        // random traffic with mid-frame pauses and transmitter backpressure
        seq_data = 0; start_pct = 40; len_min = 1; len_max = 6;
        ready_pct = 70; pause_pct = 5; pause_max = 20;
        repeat (3000) cycle();

        // transmitter stalled for 50 cycles during grants
        start_pct = 100; pause_pct = 0; ready_pct = 0;
        repeat (50) cycle();
        ready_pct = 100;
        repeat (30) cycle();

        // reset in the middle of a frame, then everybody requests
        start_pct = 40; ready_pct = 70; len_min = 3; len_max = 6;
        for (int k = 0; k < 500; k++) begin
            if (own[0] >= 0 && p_sent[0][own[0]] > 0) break;
            cycle();
        end
        check_eq("d0_mid_frame_reached", (own[0] >= 0) && (p_sent[0][own[0]] > 0), 1);
        start_pct = 100;
        do_reset(0);
        cycle();
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d_post_rst_grant_valid", d), grant_valid[d], 1);
            check_eq($sformatf("d%0d_post_rst_grant_index", d), grant_index[d], 0);
        end
        start_pct = 40;
        repeat (40) cycle();

        check_eq("d0_queue_drained", exp_q0.size(), 0);
        check_eq("d1_queue_drained", exp_q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
